// File: rtl/arith_pkg.sv
// arith_pkg: shared widths and FSM encoding for the arithmetic unit (multiplier and divider)
package arith_pkg;

    localparam int DIV_N = 8;
    localparam int DW    = 2 * DIV_N + 1;
    localparam int SW    = DIV_N + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring step, shifting {prem,qmag} left and conditionally subtracting
module div_step #(
    parameter int N = 8
) (
    input  logic [N:0]   prem,
    input  logic [2*N:0] qmag,
    input  logic [N:0]   dmag,
    output logic [N:0]   prem_nx,
    output logic [2*N:0] qmag_nx
);
    logic [N+1:0] sh;
    logic [N+1:0] diff;

    // prem < |divisor| <= 2^N keeps the shifted value below 2^(N+1), so diff's MSB is the borrow
    always_comb begin
        sh      = {prem, qmag[2*N]};
        diff    = sh - {1'b0, dmag};
        prem_nx = diff[N+1] ? sh[N:0] : diff[N:0];
        qmag_nx = {qmag[2*N-1:0], ~diff[N+1]};
    end

endmodule

// File: rtl/seq_signed_divider.sv
// seq_signed_divider: signed 2N+1 / N+1 bit sequential divider with valid/ready handshakes
module seq_signed_divider
    import arith_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [SW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] quotient,
    output logic [SW-1:0] remainder,
    output logic          dbz,
    output logic          ovf
);
    localparam int CW = $clog2(DW);
    localparam logic [DW-1:0] QMAX = {1'b0, {(DW-1){1'b1}}};

    div_state_t    state;
    div_state_t    next_state;
    logic [CW-1:0] cnt;
    logic          sa;
    logic          sb;
    logic          zdiv;
    logic          qneg;
    logic          ovf_c;
    logic [DW-1:0] qmag;
    logic [DW-1:0] qmag_nx;
    logic [SW-1:0] prem;
    logic [SW-1:0] prem_nx;
    logic [SW-1:0] dmag;

    assign qneg  = sa ^ sb;
    assign ovf_c = !zdiv && !qneg && qmag[DW-1];

    div_step #(.N(DIV_N)) u_step (
        .prem    (prem),
        .qmag    (qmag),
        .dmag    (dmag),
        .prem_nx (prem_nx),
        .qmag_nx (qmag_nx)
    );

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // next-state and handshake outputs
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) next_state = (divisor == '0) ? FIX : CALC;
            end
            CALC: if (cnt == '0) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // operand capture, iteration and sign fix-up into the held result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            sa        <= 1'b0;
            sb        <= 1'b0;
            zdiv      <= 1'b0;
            qmag      <= '0;
            prem      <= '0;
            dmag      <= '0;
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    sa   <= dividend[DW-1];
                    sb   <= divisor[SW-1];
                    qmag <= dividend[DW-1] ? -dividend : dividend;
                    dmag <= divisor[SW-1] ? -divisor : divisor;
                    prem <= '0;
                    cnt  <= CW'(DW - 1);
                    zdiv <= divisor == '0;
                    dbz  <= 1'b0;
                    ovf  <= 1'b0;
                end
                CALC: begin
                    prem <= prem_nx;
                    qmag <= qmag_nx;
                    cnt  <= cnt - 1'b1;
                end
                FIX: begin
                    quotient  <= zdiv ? (sa ? -QMAX : QMAX) : ovf_c ? QMAX : qneg ? -qmag : qmag;
                    remainder <= (zdiv || ovf_c) ? '0 : sa ? -prem : prem;
                    dbz       <= zdiv;
                    ovf       <= ovf_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb_seq_signed_divider: scoreboard bench for the sequential signed divider
module tb_seq_signed_divider;
    import arith_pkg::*;

    typedef struct {
        logic signed [31:0] q;
        logic signed [31:0] r;
        logic               d;
        logic               o;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] dividend = '0;
    logic [SW-1:0] divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] quotient;
    logic [SW-1:0] remainder;
    logic          dbz;
    logic          ovf;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   first_cyc = 0;
    logic ov_d = 1'b0;
    exp_t sb[$];

    seq_signed_divider dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, want);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        e.d = 1'b0;
        e.o = 1'b0;
        if (b == 0) begin
            e.q = (a < 0) ? -65535 : 65535;
            e.r = 0;
            e.d = 1'b1;
        end else if (a == -65536 && b == -1) begin
            e.q = 65535;
            e.r = 0;
            e.o = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    // scoreboard: compare every transferred result against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && !ov_d) first_cyc = cyc;
        ov_d = out_valid;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = sb.pop_front();
                check("quotient", $signed(quotient), e.q);
                check("remainder", $signed(remainder), e.r);
                check("dbz", dbz, e.d);
                check("ovf", ovf, e.o);
            end
            n_out++;
        end
    end

    task automatic do_op(input int a, input int b, input exp_t e);
        int t;
        @(posedge clk);
        #2;
        dividend = DW'(a);
        divisor  = SW'(b);
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        sb.push_back(e);
        @(posedge clk);
        #2;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        dividend = DW'($urandom);
        divisor  = SW'($urandom);
    endtask

    task automatic wait_out(input int target);
        int t = 0;
        while (n_out < target && t < 200) begin
            t++;
            @(negedge clk);
        end
        if (n_out < target) check("out_timeout", n_out, target);
        @(negedge clk);
    endtask

    function automatic exp_t mk(input int q, input int r, input logic d, input logic o);
        exp_t e;
        e.q = q;
        e.r = r;
        e.d = d;
        e.o = o;
        return e;
    endfunction

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int b;
        int t;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_flags", {dbz, ovf}, 0);

        do_op(100, 7, mk(14, 2, 0, 0));
        wait_out(1);
        check("latency_100_7", first_cyc - acc_cyc + 1, 19);

        do_op(-100, 7, mk(-14, -2, 0, 0));
        do_op(100, -7, mk(-14, 2, 0, 0));
        do_op(-100, -7, mk(14, -2, 0, 0));
        do_op(-65536, -1, mk(65535, 0, 0, 1));
        do_op(65535, -256, mk(-255, 255, 0, 0));
        do_op(-65536, 1, mk(-65536, 0, 0, 0));
        do_op(0, -3, mk(0, 0, 0, 0));
        wait_out(8);

        do_op(1234, 0, mk(65535, 0, 1, 0));
        wait_out(9);
        check("latency_dbz_pos", first_cyc - acc_cyc + 1, 2);
        do_op(-5, 0, mk(-65535, 0, 1, 0));
        wait_out(10);
        check("latency_dbz_neg", first_cyc - acc_cyc + 1, 2);

        out_ready = 1'b0;
        do_op(100, 7, mk(14, 2, 0, 0));
        t = 0;
        while (!out_valid && t < 50) begin
            t++;
            @(negedge clk);
        end
        check("bp_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            in_valid = i[0];
            dividend = DW'(5);
            divisor  = SW'(1);
            @(negedge clk);
            check("bp_quotient", $signed(quotient), 14);
            check("bp_remainder", $signed(remainder), 2);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        @(posedge clk);
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_after_in_ready", in_ready, 1);
        check("bp_after_out_valid", out_valid, 0);
        check("bp_transfers", n_out, 11);

        do_op(1000, 3, mk(333, 1, 0, 0));
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        void'(sb.pop_back());
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_quotient", quotient, 0);
        check("mid_rst_remainder", remainder, 0);
        check("mid_rst_flags", {dbz, ovf}, 0);
        do_op(200, 9, mk(22, 2, 0, 0));
        wait_out(12);
        check("post_rst_count", n_out, 12);

        for (int i = 0; i < 2500; i++) begin
            a = int'($signed(DW'($urandom)));
            b = int'($signed(SW'($urandom)));
            case ($urandom_range(0, 15))
                0: a = -65536;
                1: b = -1;
                2: b = 0;
                3: b = int'($urandom_range(1, 4));
                4: a = 65535;
                5: b = -256;
                default: ;
            endcase
            do_op(a, b, model(a, b));
        end
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            t++;
            @(negedge clk);
        end
        check("drain", sb.size(), 0);
        check("total_out", n_out, 2512);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
